// File: rtl/seq_gen_pkg.sv
// Shared definitions for the generic pixel sequentializer.
//   - state_t        : frame-level FSM states
//   - calc_* helpers : derived geometry (pixels per word, beats per word,
//                      words and beats per frame)
//   - cnt_w          : counter width, never narrower than one bit
//   - params_legal   : elaboration-time legality check of the parameter set
package seq_gen_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int calc_beat_pix(input int in_w, input int pix_w);
    return in_w / pix_w;
  endfunction

  function automatic int calc_groups(input int in_w, input int pix_w, input int out_pix);
    return calc_beat_pix(in_w, pix_w) / out_pix;
  endfunction

  function automatic int calc_words(input int in_w, input int pix_w,
                                    input int rows, input int cols);
    return (rows * cols) / calc_beat_pix(in_w, pix_w);
  endfunction

  function automatic int calc_beats(input int in_w, input int pix_w, input int out_pix,
                                    input int rows, input int cols);
    return calc_words(in_w, pix_w, rows, cols) * calc_groups(in_w, pix_w, out_pix);
  endfunction

  function automatic int cnt_w(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

  function automatic bit params_legal(input int pix_w, input int in_w, input int out_pix,
                                      input int rows, input int cols);
    int bp;
    if (pix_w != 8 && pix_w != 16) return 1'b0;
    if (in_w % pix_w != 0) return 1'b0;
    bp = in_w / pix_w;
    if (!is_pow2(out_pix)) return 1'b0;
    if ((bp % out_pix) != 0 || (cols % out_pix) != 0) return 1'b0;
    if (((rows * cols) % bp) != 0) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/seq_word_buffer.sv
// Two-slot input word holding register.
// Slot A is the word currently being sliced, slot B the next word in line.
//   clk, reset  : clock, asynchronous active-high reset (empties both slots)
//   i_load      : accept i_data this cycle
//   i_data      : incoming word
//   i_advance   : last slice of A is being consumed this cycle
//   o_a_valid   : A holds a word
//   o_b_valid   : B holds a word
//   o_a_data    : contents of A
module seq_word_buffer
  import seq_gen_pkg::*;
#(
  parameter int W = 256
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_advance,
  output logic         o_a_valid,
  output logic         o_b_valid,
  output logic [W-1:0] o_a_data
);

  logic         r_a_valid;
  logic         r_b_valid;
  logic [W-1:0] r_a_data;
  logic [W-1:0] r_b_data;

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values; blocking assignments here would create ordering races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a_valid <= 1'b0;
      r_b_valid <= 1'b0;
    end else if (i_advance) begin
      // B refills A without a bubble. Without B, a word arriving in the same
      // cycle goes straight into the slot being freed.
      if (r_b_valid) begin
        r_a_valid <= 1'b1;
        r_b_valid <= 1'b0;
      end else begin
        r_a_valid <= i_load;
      end
    end else if (i_load) begin
      if (r_a_valid) r_b_valid <= 1'b1;
      else           r_a_valid <= 1'b1;
    end
  end

  // NOTE: the data slots are deliberately left without reset; the valid
  // flags above qualify them, so a reset tree on wide data buys nothing.
  always_ff @(posedge clk) begin
    if (i_advance) begin
      r_a_data <= r_b_valid ? r_b_data : i_data;
    end else if (i_load) begin
      if (r_a_valid) r_b_data <= i_data;
      else           r_a_data <= i_data;
    end
  end

  assign o_a_valid = r_a_valid;
  assign o_b_valid = r_b_valid;
  assign o_a_data  = r_a_data;

endmodule

// File: rtl/sequentializer_gen.sv
// Generic pixel sequentializer: slices IN_W-bit pixel words into beats of
// OUT_PIX pixels (PIX_W bits each), with frame sideband and ap_* control.
//   clk, reset            : clock, asynchronous active-high reset
//   ap_start/ap_ready/ap_idle/ap_done : frame-level handshake
//   cn_ap_ready           : downstream ready for a new frame
//   s_axis_*              : input word stream, pixel 0 in the LSBs
//   m_axis_*              : output beat stream, tuser = first beat, tlast = last
//   cnt_col/cnt_row       : frame position of the current beat's pixel 0
module sequentializer_gen
  import seq_gen_pkg::*;
#(
  parameter int PIX_W   = 8,
  parameter int IN_W    = 256,
  parameter int OUT_PIX = 1,
  parameter int IN_ROWS = 20,
  parameter int IN_COLS = 20
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ap_start,
  output logic                         ap_ready,
  output logic                         ap_idle,
  output logic                         ap_done,
  input  logic                         cn_ap_ready,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic [IN_W-1:0]              s_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic [OUT_PIX*PIX_W-1:0]     m_axis_tdata,
  output logic                         m_axis_tuser,
  output logic                         m_axis_tlast,
  output logic [cnt_w(IN_COLS)-1:0]    cnt_col,
  output logic [cnt_w(IN_ROWS)-1:0]    cnt_row
);

  localparam int GROUPS = calc_groups(IN_W, PIX_W, OUT_PIX);
  localparam int WORDS  = calc_words(IN_W, PIX_W, IN_ROWS, IN_COLS);
  localparam int BEATS  = calc_beats(IN_W, PIX_W, OUT_PIX, IN_ROWS, IN_COLS);
  localparam int OUT_W  = OUT_PIX * PIX_W;
  localparam int GRP_W  = cnt_w(GROUPS);
  localparam int BEAT_W = cnt_w(BEATS);
  localparam int WIN_W  = $clog2(WORDS + 1);
  localparam int COL_W  = cnt_w(IN_COLS);
  localparam int ROW_W  = cnt_w(IN_ROWS);

  if (!params_legal(PIX_W, IN_W, OUT_PIX, IN_ROWS, IN_COLS)) begin : g_param_check
    $error("sequentializer_gen: illegal parameter combination");
  end

  state_t            r_state;
  logic              r_ap_idle;
  logic              r_ap_done;
  logic [WIN_W-1:0]  r_words_in;
  logic [GRP_W-1:0]  r_grp_idx;
  logic [BEAT_W-1:0] r_beat_cnt;
  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;

  logic              w_a_valid;
  logic              w_b_valid;
  logic [IN_W-1:0]   w_a_data;
  logic              w_start;
  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_grp_last;
  logic              w_advance;
  logic              w_frame_last;
  logic [COL_W:0]    w_col_sum;
  logic              w_col_wrap;

  assign w_start    = (r_state == IDLE) && ap_start && cn_ap_ready;
  assign ap_ready   = (r_state == IDLE) && cn_ap_ready;
  assign ap_idle    = r_ap_idle;
  assign ap_done    = r_ap_done;

  // Input readiness depends on registered state only, so there is no
  // combinational path from m_axis_tready back to s_axis_tready.
  assign s_axis_tready = (r_state == RUN) && !w_b_valid && (r_words_in < WIN_W'(WORDS));

  assign w_in_fire    = s_axis_tvalid && s_axis_tready;
  assign w_out_fire   = w_a_valid && m_axis_tready;
  assign w_grp_last   = (r_grp_idx == GRP_W'(GROUPS - 1));
  assign w_advance    = w_out_fire && w_grp_last;
  assign w_frame_last = (r_beat_cnt == BEAT_W'(BEATS - 1));

  // One extra bit so a column count equal to 2**COL_W is still detected.
  assign w_col_sum  = {1'b0, r_col} + (COL_W + 1)'(OUT_PIX);
  assign w_col_wrap = (w_col_sum == (COL_W + 1)'(IN_COLS));

  seq_word_buffer #(.W(IN_W)) u_buf (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_in_fire),
    .i_data    (s_axis_tdata),
    .i_advance (w_advance),
    .o_a_valid (w_a_valid),
    .o_b_valid (w_b_valid),
    .o_a_data  (w_a_data)
  );

  assign m_axis_tvalid = w_a_valid;
  assign m_axis_tdata  = w_a_data[r_grp_idx * OUT_W +: OUT_W];
  assign m_axis_tuser  = w_a_valid && (r_beat_cnt == '0);
  assign m_axis_tlast  = w_a_valid && w_frame_last;
  assign cnt_col       = r_col;
  assign cnt_row       = r_row;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_ap_idle  <= 1'b1;
      r_ap_done  <= 1'b0;
      r_words_in <= '0;
      r_grp_idx  <= '0;
      r_beat_cnt <= '0;
      r_col      <= '0;
      r_row      <= '0;
    end else begin
      r_ap_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state    <= RUN;
            r_ap_idle  <= 1'b0;
            r_words_in <= '0;
            r_grp_idx  <= '0;
            r_beat_cnt <= '0;
            r_col      <= '0;
            r_row      <= '0;
          end
        end
        RUN: begin
          if (w_in_fire) r_words_in <= r_words_in + 1'b1;
          if (w_out_fire) begin
            r_grp_idx <= w_grp_last ? '0 : r_grp_idx + 1'b1;
            if (w_frame_last) begin
              // Frame complete: everything returns to zero for the next frame.
              r_state    <= DONE;
              r_ap_done  <= 1'b1;
              r_words_in <= '0;
              r_grp_idx  <= '0;
              r_beat_cnt <= '0;
              r_col      <= '0;
              r_row      <= '0;
            end else begin
              r_beat_cnt <= r_beat_cnt + 1'b1;
              if (w_col_wrap) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
              end else begin
                r_col <= w_col_sum[COL_W-1:0];
              end
            end
          end
        end
        DONE: begin
          r_state   <= IDLE;
          r_ap_idle <= 1'b1;
        end
        default: begin
          r_state   <= IDLE;
          r_ap_idle <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sequentializer_gen.sv
// Bench for sequentializer_gen: two instances (8-bit x1 on a 32x20 frame,
// 16-bit x4 on a 16x16 frame) with scoreboards filled on input handshakes
// and drained on output handshakes.
module tb_sequentializer_gen;

  localparam int A_PIX_W = 8,  A_OUT_PIX = 1, A_ROWS = 32, A_COLS = 20;
  localparam int A_GROUPS = 32, A_WORDS = 20, A_BEATS = 640;
  localparam int B_PIX_W = 16, B_OUT_PIX = 4, B_ROWS = 16, B_COLS = 16;
  localparam int B_GROUPS = 4, B_WORDS = 16, B_BEATS = 64;

  typedef struct {
    logic [63:0] data;
    logic        user;
    logic        last;
    int          col;
    int          row;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A
  logic         a_ap_start, a_ap_ready, a_ap_idle, a_ap_done, a_cn;
  logic         a_s_tvalid, a_s_tready, a_m_tvalid, a_m_tready, a_tuser, a_tlast;
  logic [255:0] a_s_tdata;
  logic [7:0]   a_m_tdata;
  logic [4:0]   a_col, a_row;
  // Instance B
  logic         b_ap_start, b_ap_ready, b_ap_idle, b_ap_done, b_cn;
  logic         b_s_tvalid, b_s_tready, b_m_tvalid, b_m_tready, b_tuser, b_tlast;
  logic [255:0] b_s_tdata;
  logic [63:0]  b_m_tdata;
  logic [3:0]   b_col, b_row;

  sequentializer_gen #(.PIX_W(A_PIX_W), .IN_W(256), .OUT_PIX(A_OUT_PIX),
                       .IN_ROWS(A_ROWS), .IN_COLS(A_COLS)) dut_a (
    .clk(clk), .reset(rst), .ap_start(a_ap_start), .ap_ready(a_ap_ready),
    .ap_idle(a_ap_idle), .ap_done(a_ap_done), .cn_ap_ready(a_cn),
    .s_axis_tvalid(a_s_tvalid), .s_axis_tready(a_s_tready), .s_axis_tdata(a_s_tdata),
    .m_axis_tvalid(a_m_tvalid), .m_axis_tready(a_m_tready), .m_axis_tdata(a_m_tdata),
    .m_axis_tuser(a_tuser), .m_axis_tlast(a_tlast), .cnt_col(a_col), .cnt_row(a_row)
  );

  sequentializer_gen #(.PIX_W(B_PIX_W), .IN_W(256), .OUT_PIX(B_OUT_PIX),
                       .IN_ROWS(B_ROWS), .IN_COLS(B_COLS)) dut_b (
    .clk(clk), .reset(rst), .ap_start(b_ap_start), .ap_ready(b_ap_ready),
    .ap_idle(b_ap_idle), .ap_done(b_ap_done), .cn_ap_ready(b_cn),
    .s_axis_tvalid(b_s_tvalid), .s_axis_tready(b_s_tready), .s_axis_tdata(b_s_tdata),
    .m_axis_tvalid(b_m_tvalid), .m_axis_tready(b_m_tready), .m_axis_tdata(b_m_tdata),
    .m_axis_tuser(b_tuser), .m_axis_tlast(b_tlast), .cnt_col(b_col), .cnt_row(b_row)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  exp_t a_q[$];
  exp_t b_q[$];
  int a_pushed = 0, a_popped = 0, a_occ = 0, a_words = 0;
  int a_done_cnt = 0, a_frame_beats = 0, a_last_cyc = -10;
  int b_pushed = 0, b_popped = 0, b_done_cnt = 0, b_frame_beats = 0;
  int b_first_in = -10, b_first_out = -10, b_last_cyc = -10;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Input word w of a frame: pixel index modulo 2**pix_w in every lane.
  function automatic logic [255:0] word_data(input int w, input int pix_w);
    logic [255:0] d;
    int bp;
    d  = '0;
    bp = 256 / pix_w;
    for (int k = 0; k < bp; k++) begin
      logic [15:0] v;
      v = 16'((w * bp + k) % (1 << pix_w));
      d = d | (256'(v) << (k * pix_w));
    end
    return d;
  endfunction

  function automatic exp_t make_exp(input int beat, input int pix_w, input int out_pix,
                                    input int cols, input int beats);
    exp_t e;
    e.data = '0;
    for (int j = 0; j < out_pix; j++) begin
      logic [63:0] v;
      v = 64'((beat * out_pix + j) % (1 << pix_w));
      e.data = e.data | (v << (j * pix_w));
    end
    e.col  = (beat * out_pix) % cols;
    e.row  = (beat * out_pix) / cols;
    e.user = (beat == 0);
    e.last = (beat == beats - 1);
    return e;
  endfunction

  task automatic count_cycles();
    forever begin
      @(posedge clk);
      cyc++;
    end
  endtask

  task automatic monitor_a();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        a_q.delete();
        a_pushed = 0; a_popped = 0; a_occ = 0; a_words = 0;
      end else begin
        if (a_occ == 2)       check("a_tready_both_full", 64'(a_s_tready), 64'(0));
        if (a_words == A_WORDS) check("a_tready_all_words", 64'(a_s_tready), 64'(0));
        if (a_s_tvalid && a_s_tready) begin
          for (int g = 0; g < A_GROUPS; g++)
            a_q.push_back(make_exp(a_pushed + g, A_PIX_W, A_OUT_PIX, A_COLS, A_BEATS));
          a_pushed += A_GROUPS;
          a_words++;
          a_occ++;
        end
        if (a_m_tvalid && a_m_tready) begin
          if (a_q.size() == 0) begin
            check("a_unexpected_beat", 64'(1), 64'(0));
          end else begin
            e = a_q.pop_front();
            check("a_tdata", 64'(a_m_tdata), e.data);
            check("a_tuser", 64'(a_tuser), 64'(e.user));
            check("a_tlast", 64'(a_tlast), 64'(e.last));
            check("a_cnt_col", 64'(a_col), 64'(e.col));
            check("a_cnt_row", 64'(a_row), 64'(e.row));
          end
          a_popped++;
          if (a_popped % A_GROUPS == 0) a_occ--;
          if (a_tlast) a_last_cyc = cyc;
        end
        if (a_ap_done) begin
          check("a_done_latency", 64'(cyc), 64'(a_last_cyc + 1));
          a_done_cnt++;
          a_frame_beats = a_popped;
          a_pushed = 0; a_popped = 0; a_occ = 0; a_words = 0;
        end
      end
    end
  endtask

  task automatic monitor_b();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        b_q.delete();
        b_pushed = 0; b_popped = 0;
      end else begin
        if (b_s_tvalid && b_s_tready) begin
          if (b_pushed == 0) b_first_in = cyc;
          for (int g = 0; g < B_GROUPS; g++)
            b_q.push_back(make_exp(b_pushed + g, B_PIX_W, B_OUT_PIX, B_COLS, B_BEATS));
          b_pushed += B_GROUPS;
        end
        if (b_m_tvalid && b_m_tready) begin
          if (b_q.size() == 0) begin
            check("b_unexpected_beat", 64'(1), 64'(0));
          end else begin
            e = b_q.pop_front();
            check("b_tdata", b_m_tdata, e.data);
            check("b_tuser", 64'(b_tuser), 64'(e.user));
            check("b_tlast", 64'(b_tlast), 64'(e.last));
            check("b_cnt_col", 64'(b_col), 64'(e.col));
            check("b_cnt_row", 64'(b_row), 64'(e.row));
            if (e.user) begin
              b_first_out = cyc;
              check("b_first_latency", 64'(cyc), 64'(b_first_in + 1));
            end
          end
          b_popped++;
          if (b_tlast) b_last_cyc = cyc;
        end
        if (b_ap_done) begin
          check("b_done_latency", 64'(cyc), 64'(b_last_cyc + 1));
          check("b_no_gaps", 64'(b_last_cyc - b_first_out), 64'(B_BEATS - 1));
          b_done_cnt++;
          b_frame_beats = b_popped;
          b_pushed = 0; b_popped = 0;
        end
      end
    end
  endtask

  // One frame on instance A. rnd: random input valid and 30% output ready.
  // pulse_mid: extra ap_start pulses mid-frame. abort_at >= 0: reset after
  // that many output beats.
  task automatic run_a(input bit rnd, input bit pulse_mid, input int abort_at);
    int  w, done0, it;
    bit  hs, fin;
    w = 0; done0 = a_done_cnt; fin = 1'b0; it = 0;
    a_ap_start = 1'b1;
    while (!fin && it < 20000) begin
      it++;
      @(negedge clk);
      hs = a_s_tvalid && a_s_tready;
      @(posedge clk);
      #1;
      if (a_done_cnt != done0) begin
        fin = 1'b1;
        a_ap_start = 1'b0;
        a_s_tvalid = 1'b0;
        a_m_tready = 1'b0;
      end else begin
        if (hs) w++;
        a_ap_start = pulse_mid && (a_popped >= 50) && (a_popped < 56);
        if (!(a_s_tvalid && !hs))
          a_s_tvalid = (w < A_WORDS) && (!rnd || $urandom_range(1) == 1);
        a_s_tdata  = word_data(w, A_PIX_W);
        a_m_tready = !rnd || ($urandom_range(9) < 3);
        if (abort_at >= 0 && a_popped >= abort_at) begin
          rst = 1'b1;
          #1;
          check("a_rst_idle", 64'(a_ap_idle), 64'(1));
          check("a_rst_done", 64'(a_ap_done), 64'(0));
          check("a_rst_s_tready", 64'(a_s_tready), 64'(0));
          check("a_rst_m_tvalid", 64'(a_m_tvalid), 64'(0));
          check("a_rst_tuser", 64'(a_tuser), 64'(0));
          check("a_rst_tlast", 64'(a_tlast), 64'(0));
          check("a_rst_col", 64'(a_col), 64'(0));
          check("a_rst_row", 64'(a_row), 64'(0));
          a_ap_start = 1'b0;
          a_s_tvalid = 1'b0;
          a_m_tready = 1'b0;
          repeat (2) @(posedge clk);
          #1;
          rst = 1'b0;
          return;
        end
      end
    end
    if (!fin) begin
      check("a_frame_timeout", 64'(0), 64'(1));
      return;
    end
    repeat (4) @(posedge clk);
    #1;
    check("a_done_count", 64'(a_done_cnt - done0), 64'(1));
    check("a_frame_beats", 64'(a_frame_beats), 64'(A_BEATS));
    check("a_idle_after", 64'(a_ap_idle), 64'(1));
    check("a_tvalid_after", 64'(a_m_tvalid), 64'(0));
  endtask

  task automatic run_b();
    int w, done0, it;
    bit hs, fin;
    w = 0; done0 = b_done_cnt; fin = 1'b0; it = 0;
    b_ap_start = 1'b1;
    b_m_tready = 1'b1;
    while (!fin && it < 5000) begin
      it++;
      @(negedge clk);
      hs = b_s_tvalid && b_s_tready;
      @(posedge clk);
      #1;
      b_ap_start = 1'b0;
      if (b_done_cnt != done0) begin
        fin = 1'b1;
        b_s_tvalid = 1'b0;
      end else begin
        if (hs) w++;
        b_s_tvalid = (w < B_WORDS);
        b_s_tdata  = word_data(w, B_PIX_W);
      end
    end
    if (!fin) begin
      check("b_frame_timeout", 64'(0), 64'(1));
      return;
    end
    repeat (4) @(posedge clk);
    #1;
    check("b_done_count", 64'(b_done_cnt - done0), 64'(1));
    check("b_frame_beats", 64'(b_frame_beats), 64'(B_BEATS));
    check("b_idle_after", 64'(b_ap_idle), 64'(1));
  endtask

  initial begin
    rst = 1'b1;
    a_ap_start = 1'b0; a_cn = 1'b1; a_s_tvalid = 1'b0; a_s_tdata = '0; a_m_tready = 1'b0;
    b_ap_start = 1'b0; b_cn = 1'b1; b_s_tvalid = 1'b0; b_s_tdata = '0; b_m_tready = 1'b0;
    fork
      count_cycles();
      monitor_a();
      monitor_b();
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ap_idle", 64'(a_ap_idle), 64'(1));
    check("rst_ap_done", 64'(a_ap_done), 64'(0));
    check("rst_s_tready", 64'(a_s_tready), 64'(0));
    check("rst_m_tvalid", 64'(a_m_tvalid), 64'(0));
    check("rst_tuser", 64'(a_tuser), 64'(0));
    check("rst_tlast", 64'(a_tlast), 64'(0));
    check("rst_cnt_col", 64'(a_col), 64'(0));
    check("rst_cnt_row", 64'(a_row), 64'(0));
    check("rst_ap_ready_cn1", 64'(a_ap_ready), 64'(1));
    check("rst_b_ap_ready", 64'(b_ap_ready), 64'(1));
    a_cn = 1'b0;
    #1;
    check("rst_ap_ready_cn0", 64'(a_ap_ready), 64'(0));
    a_cn = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Full frame, no stalls, 8-bit x1
    run_a(1'b0, 1'b0, -1);
    // Full frame, no stalls, 16-bit x4
    run_b();
    // Random backpressure and input gaps
    run_a(1'b1, 1'b0, -1);

    // ap_start while downstream is not ready
    a_cn = 1'b0;
    a_ap_start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("nocn_idle", 64'(a_ap_idle), 64'(1));
    check("nocn_s_tready", 64'(a_s_tready), 64'(0));
    check("nocn_ap_ready", 64'(a_ap_ready), 64'(0));
    a_ap_start = 1'b0;
    a_cn = 1'b1;
    #1;
    check("cn_ap_ready", 64'(a_ap_ready), 64'(1));
    @(posedge clk);
    #1;
    run_a(1'b0, 1'b0, -1);

    // Reset mid-frame, then a clean frame
    run_a(1'b0, 1'b0, 100);
    run_a(1'b0, 1'b0, -1);

    // ap_start pulses during RUN are ignored
    run_a(1'b1, 1'b1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
